// File: rtl/sm83_pkg.sv
// Shared sm83 bus types plus the timer register addresses, TAC layout and reload FSM states.
package sm83_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam addr_t TIMER_DIV_ADDR  = 16'hFF04;
  localparam addr_t TIMER_TIMA_ADDR = 16'hFF05;
  localparam addr_t TIMER_TMA_ADDR  = 16'hFF06;
  localparam addr_t TIMER_TAC_ADDR  = 16'hFF07;

  typedef struct packed {
    logic       enable;
    logic [1:0] sel;
  } tac_t;

  typedef enum logic {
    TMR_IDLE,
    TMR_RELOAD
  } timer_state_t;
endpackage

// File: rtl/sm83_timer.sv
// DIV/TIMA/TMA/TAC timer: free-running divider, selectable falling-edge TIMA tick,
// and a delayed TMA reload that raises a one-cycle irq.
module sm83_timer
  import sm83_pkg::*;
#(
  parameter int    RELOAD_DELAY = 4,
  parameter addr_t BASE_ADDR    = TIMER_DIV_ADDR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t addr,
  input  data_t w_data,
  input  logic  w_wen,
  output data_t r_data,
  output logic  r_hit,
  output logic  irq
);
  localparam logic [1:0] OFS_DIV    = 2'(TIMER_DIV_ADDR - TIMER_DIV_ADDR);
  localparam logic [1:0] OFS_TIMA   = 2'(TIMER_TIMA_ADDR - TIMER_DIV_ADDR);
  localparam logic [1:0] OFS_TMA    = 2'(TIMER_TMA_ADDR - TIMER_DIV_ADDR);
  localparam logic [1:0] OFS_TAC    = 2'(TIMER_TAC_ADDR - TIMER_DIV_ADDR);
  localparam logic [2:0] DELAY_INIT = 3'(RELOAD_DELAY - 1);

  logic [15:0]  sys_cnt_q, sys_cnt_d;
  data_t        tima_q;
  data_t        tma_q, tma_d;
  tac_t         tac_q, tac_d;
  timer_state_t state_q;
  logic [2:0]   delay_q;
  logic         tick_prev_q;
  logic         irq_q;

  addr_t      ofs;
  logic       wr_div, wr_tima, wr_tma, wr_tac;
  logic [3:0] taps;
  logic       tick_now, tick_fall;

  assign ofs     = addr - BASE_ADDR;
  assign r_hit   = (ofs[15:2] == 14'd0);
  assign wr_div  = w_wen & r_hit & (ofs[1:0] == OFS_DIV);
  assign wr_tima = w_wen & r_hit & (ofs[1:0] == OFS_TIMA);
  assign wr_tma  = w_wen & r_hit & (ofs[1:0] == OFS_TMA);
  assign wr_tac  = w_wen & r_hit & (ofs[1:0] == OFS_TAC);

  // Divider taps indexed by TAC.sel: 00->bit9, 01->bit3, 10->bit5, 11->bit7.
  assign taps      = {sys_cnt_q[7], sys_cnt_q[5], sys_cnt_q[3], sys_cnt_q[9]};
  assign tick_now  = tac_q.enable & taps[tac_q.sel];
  assign tick_fall = tick_prev_q & ~tick_now;

  assign sys_cnt_d = wr_div ? 16'd0 : sys_cnt_q + 16'd1;
  assign tma_d     = wr_tma ? w_data : tma_q;
  assign tac_d     = wr_tac ? tac_t'(w_data[2:0]) : tac_q;
  assign irq       = irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_cnt_q   <= 16'd0;
      tima_q      <= 8'h00;
      tma_q       <= 8'h00;
      tac_q       <= '0;
      state_q     <= TMR_IDLE;
      delay_q     <= 3'd0;
      tick_prev_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sys_cnt_q   <= sys_cnt_d;
      tma_q       <= tma_d;
      tac_q       <= tac_d;
      tick_prev_q <= tick_now;
      irq_q       <= 1'b0;
      if (wr_tima) begin
        // A CPU write wins over any increment and abandons a pending reload.
        tima_q  <= w_data;
        state_q <= TMR_IDLE;
        delay_q <= 3'd0;
      end else if (state_q == TMR_RELOAD && delay_q == 3'd0) begin
        tima_q  <= tma_d;
        irq_q   <= 1'b1;
        state_q <= TMR_IDLE;
      end else begin
        if (state_q == TMR_RELOAD) begin
          delay_q <= delay_q - 3'd1;
        end
        if (tick_fall) begin
          if (tima_q == 8'hFF) begin
            tima_q  <= 8'h00;
            state_q <= TMR_RELOAD;
            delay_q <= DELAY_INIT;
          end else begin
            tima_q <= tima_q + 8'h01;
          end
        end
      end
    end
  end

  always_comb begin
    r_data = 8'h00;
    if (r_hit) begin
      case (ofs[1:0])
        OFS_DIV:  r_data = sys_cnt_q[15:8];
        OFS_TIMA: r_data = tima_q;
        OFS_TMA:  r_data = tma_q;
        default:  r_data = {5'b11111, tac_q};
      endcase
    end
  end
endmodule

// File: doc/sm83_timer.md
Name: sm83_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer peripheral on the sm83 CPU bus at 0xFF04–0xFF07.
- Sits beside the ROM/WRAM/HRAM decode in the top level. It consumes the same addr/w_data/w_wen the core drives.
- Returns read data plus a hit strobe that the top-level read mux selects.
- Produces a one-cycle timer interrupt request for the downstream interrupt-flag logic.

Parameters:
- RELOAD_DELAY, 4, clocks between a TIMA overflow and the TMA reload / irq pulse; legal range 1..7.
- BASE_ADDR, 16'hFF04, address of DIV; TIMA, TMA and TAC follow at +1, +2, +3.

Ports:
- clk  in  1  system clock; one clk = one T-cycle.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  addr_t(16)  bus address from the core.
- w_data  in  data_t(8)  bus write data.
- w_wen  in  1  write strobe, qualified by addr.
- r_data  out  data_t(8)  read data for the addressed register; 0 when not hit.
- r_hit  out  1  addr is within BASE_ADDR..BASE_ADDR+3 (combinational).
- irq  out  1  timer interrupt request; one-cycle pulse.

Behaviour:
- Reset values (asynchronous, active-low; applies even mid-operation):
  - sys_cnt[15:0]=0, TIMA=0, TMA=0, TAC=0.
  - Reload pending cleared, delay counter=0.
  - irq=0. r_data follows the reset register values (DIV reads 0).
- Register map and reads (reads are combinational, same cycle):
  - DIV reads sys_cnt[15:8].
  - TIMA and TMA read as stored.
  - TAC reads {5'b11111, TAC[2:0]}.
- sys_cnt increments by 1 every clk and wraps at 16'hFFFF to 0.
- Any write to DIV clears sys_cnt to 0 on that edge; w_data is ignored.
- Tick select, by TAC[1:0]: 00→sys_cnt[9], 01→sys_cnt[3], 10→sys_cnt[5], 11→sys_cnt[7].
- tick_in = TAC[2] & selected bit.
  - A TIMA increment occurs on a 1→0 transition of tick_in between consecutive cycles.
  - This includes falling edges caused by a DIV write, a TAC disable, or a TAC select change.
  - Edge detection is a registered previous tick_in.
- Increment when TIMA=8'hFF:
  - TIMA becomes 8'h00 and the RELOAD state is entered with delay counter=RELOAD_DELAY-1.
- States: IDLE, RELOAD.
  - RELOAD counts down each clk.
  - On the cycle the count reaches 0: TIMA←TMA (the TMA value current on that cycle, including a same-cycle TMA write), irq=1 for that one cycle, then return to IDLE.
  - A CPU write to TIMA while in RELOAD cancels the reload: TIMA←w_data, no irq, state→IDLE.
  - A timer increment while in RELOAD (TIMA=0) increments TIMA normally without cancelling the reload.
- Write/increment priority in IDLE:
  - A TIMA write beats a same-cycle increment; the written value is kept and no increment is applied.
  - A TAC write takes effect for tick_in on the next cycle. The falling-edge rule above then applies.
- Writes with addr outside the window are ignored; r_hit=0 and r_data=0.

Decomposition:
- sm83_pkg gets:
  - TIMER_DIV_ADDR/TIMA/TMA/TAC constants.
  - tac_t packed struct {enable, sel[1:0]}.
  - timer_state_t enum {TMR_IDLE, TMR_RELOAD}.
- No sub-module is needed; the whole block is a single always_ff plus read mux.
- Integration (separate change): the top-level read mux gets a hit check for the timer range, and irq feeds the IF bit 2 set logic.

Test Plan:
- Reset, then read FF04..FF07 → 8'h00, 8'h00, 8'h00, 8'hF8. irq stays 0 for 1000 clk with TAC=0.
- Write TAC=8'h05, TMA=8'h80, TIMA=8'hFE, then DIV write at t0.
  - TIMA=FF at t0+16, 00 at t0+32.
  - At t0+32+RELOAD_DELAY: TIMA=80 and irq high exactly 1 cycle.
- Overflow, then a TIMA write of 8'h33 two clk later → TIMA=33, no irq, no reload to TMA.
- TAC=05 with sys_cnt[3]=1, write DIV → TIMA increments by exactly 1. DIV then reads 00 for 256 clk, then 01.
- Write TMA=8'h44 on the reload cycle → TIMA reloads 44 and irq pulses.
- Assert rst_n low for 1 clk during RELOAD → all registers 0, irq never pulses, and counting resumes from 0 after release.
